// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: arbiter state encoding and last_grant reset value, shared by reg_load_arbiter.
package reg_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, ACK} state_e;
  function automatic int last_grant_rst(input int nreq);
    return nreq - 1;
  endfunction
endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after start with wrap-around.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j   = '0;
    // Scan farthest-first so the candidate closest to start is the last to overwrite idx.
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IW'((int'(start) + i) % NREQ);
      if (req[j]) idx = j;
    end
    valid = |req;
  end
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin owner of a load-enabled register's Din/load port.
// Define REG_ARB_READBACK_EN to add the CHECK state and sticky rb_err readback compare.
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IW    = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      reg_din,
  output logic                  reg_load,
  input  logic [WIDTH-1:0]      reg_q,
  output logic                  busy,
  output logic [IW-1:0]         last_grant,
  output logic                  rb_err
);
  localparam logic [IW-1:0] LAST_RST = IW'(last_grant_rst(NREQ));
`ifdef REG_ARB_READBACK_EN
  localparam state_e AFTER_LOAD = CHECK;
`else
  localparam state_e AFTER_LOAD = ACK;
`endif
  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, last_q, last_d, start, win;
  logic [WIDTH-1:0]  din_q, din_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              load_q, load_d, valid;
  assign start = (last_q == LAST_RST) ? '0 : last_q + 1'b1;
  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req  (req),
    .start(start),
    .valid(valid),
    .idx  (win)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    din_d   = din_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = LOAD;
        idx_d   = win;
        for (int i = 0; i < NREQ; i++)
          if (IW'(i) == win) din_d = req_data[i*WIDTH +: WIDTH];
      end
      LOAD: state_d = AFTER_LOAD;
      ACK: begin
        state_d = IDLE;
        last_d  = idx_q;
      end
      default: state_d = ACK;
    endcase
    load_d = state_d == LOAD;
    ack_d  = (state_d == ACK) ? NREQ'(1) << idx_d : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      din_q   <= '0;
      last_q  <= LAST_RST;
      ack_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
    end
`ifdef REG_ARB_READBACK_EN
  logic err_q, err_d;
  assign err_d = err_q | (state_q == CHECK && reg_q != din_q);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign rb_err = err_q;
`else
  logic unused_reg_q;
  assign unused_reg_q = ^reg_q;
  assign rb_err = 1'b0;
`endif
  assign ack        = ack_q;
  assign reg_din    = din_q;
  assign reg_load   = load_q;
  assign busy       = state_q != IDLE;
  assign last_grant = last_q;
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: directed and randomized checks of reg_load_arbiter against a round-robin model.
module tb_reg_load_arbiter;
`ifdef REG_ARB_READBACK_EN
  localparam int LAT = 3;
  localparam bit RB  = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit RB  = 1'b0;
`endif
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic [7:0]  reg_din, reg_q;
  logic        reg_load, busy, rb_err;
  logic [1:0]  last_grant;
  logic [7:0]  q_reg = '0;
  logic [7:0]  force_val = '0;
  logic        force_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          lg_m;
  always #5 clock = ~clock;
  always @(posedge clock) if (reg_load) q_reg <= reg_din;
  assign reg_q = force_en ? force_val : q_reg;
  reg_load_arbiter dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
    .ack(ack), .reg_din(reg_din), .reg_load(reg_load), .reg_q(reg_q),
    .busy(busy), .last_grant(last_grant), .rb_err(rb_err)
  );
  function automatic int pick(input logic [3:0] m, input int lg);
    for (int k = 1; k <= 4; k++) if (m[(lg + k) % 4]) return (lg + k) % 4;
    return -1;
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    lg_m = 3;
  endtask
  task automatic wait_ack(output int idx, output int loads, output logic [7:0] ld, output int cyc);
    idx = -1; loads = 0; ld = '0; cyc = 0;
    for (int c = 0; c < 12 && idx == -1; c++) begin
      step();
      cyc++;
      if (reg_load) begin loads++; ld = reg_din; end
      if (ack != 0) idx = ($countones(ack) == 1) ? $clog2(ack) : -2;
    end
  endtask
  task automatic test_reset();
    int idx, loads, cyc;
    logic [7:0] ld;
    req = 4'hF;
    req_data = 32'h44332211;
    reset_n = 1'b0;
    step();
    step();
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h expected 0", ack); end
    checks++; if (reg_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", reg_load); end
    checks++; if (reg_din !== 8'h00) begin errors++; $display("FAIL reset_din: got %h expected 00", reg_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (last_grant !== 2'd3) begin errors++; $display("FAIL reset_last_grant: got %0d expected 3", last_grant); end
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL reset_rb_err: got %b expected 0", rb_err); end
    reset_n = 1'b1;
    wait_ack(idx, loads, ld, cyc);
    req = '0;
    checks++; if (idx !== 0) begin errors++; $display("FAIL reset_first_ack: got %0d expected 0", idx); end
    checks++; if (cyc !== LAT) begin errors++; $display("FAIL reset_latency: got %0d expected %0d", cyc, LAT); end
    step();
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL ack_one_cycle: got %h expected 0", ack); end
  endtask
  task automatic test_all_four();
    int idx, loads, cyc;
    logic [7:0] ld, exp_d;
    do_reset();
    req = 4'hF;
    req_data = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'(8'h11 * (k + 1));
      wait_ack(idx, loads, ld, cyc);
      if (idx >= 0) req[idx] = 1'b0;
      checks++; if (idx !== k) begin errors++; $display("FAIL all4_order[%0d]: got %0d expected %0d", k, idx, k); end
      checks++; if (loads !== 1 || ld !== exp_d) begin errors++; $display("FAIL all4_load[%0d]: got %0d pulses din %h expected 1 pulse din %h", k, loads, ld, exp_d); end
      checks++; if (q_reg !== exp_d) begin errors++; $display("FAIL all4_q[%0d]: got %h expected %h", k, q_reg, exp_d); end
      checks++; if (cyc !== ((k == 0) ? LAT : LAT + 1)) begin errors++; $display("FAIL all4_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? LAT : LAT + 1); end
    end
    req = '0;
    step();
  endtask
  task automatic test_single();
    int idx, loads, cyc;
    logic [7:0] ld;
    req_data = 32'h00FF0000;
    req = 4'b0100;
    wait_ack(idx, loads, ld, cyc);
    req = '0;
    checks++; if (idx !== 2) begin errors++; $display("FAIL single_ack: got %0d expected 2", idx); end
    checks++; if (loads !== 1 || ld !== 8'hFF) begin errors++; $display("FAIL single_load: got %0d pulses din %h expected 1 pulse din ff", loads, ld); end
    checks++; if (q_reg !== 8'hFF) begin errors++; $display("FAIL single_q: got %h expected ff", q_reg); end
    req_data = 32'h12345678;
    repeat (3) step();
    checks++; if (reg_din !== 8'hFF || busy !== 1'b0) begin errors++; $display("FAIL single_hold: got din %h busy %b expected din ff busy 0", reg_din, busy); end
    checks++; if (last_grant !== 2'd2) begin errors++; $display("FAIL single_last_grant: got %0d expected 2", last_grant); end
  endtask
  task automatic test_wrap();
    int idx, loads, cyc;
    int exp_o[3] = '{3, 0, 1};
    logic [7:0] ld;
    logic [7:0] d[4];
    for (int j = 0; j < 4; j++) begin d[j] = 8'($urandom); req_data[j*8 +: 8] = d[j]; end
    req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      wait_ack(idx, loads, ld, cyc);
      if (idx >= 0) req[idx] = 1'b0;
      checks++; if (idx !== exp_o[k]) begin errors++; $display("FAIL wrap_order[%0d]: got %0d expected %0d", k, idx, exp_o[k]); end
      checks++; if (q_reg !== d[exp_o[k]]) begin errors++; $display("FAIL wrap_q[%0d]: got %h expected %h", k, q_reg, d[exp_o[k]]); end
    end
    req = '0;
    step();
    checks++; if (last_grant !== 2'd1) begin errors++; $display("FAIL wrap_last_grant: got %0d expected 1", last_grant); end
  endtask
  task automatic test_req_drop();
    int idx, loads, cyc;
    logic [7:0] ld;
    req_data = 32'h0000F000;
    req = 4'b0010;
    step();
    checks++; if (reg_load !== 1'b1 || reg_din !== 8'hF0) begin errors++; $display("FAIL drop_load: got load %b din %h expected load 1 din f0", reg_load, reg_din); end
    req = '0;
    req_data = 32'h00000F00;
    wait_ack(idx, loads, ld, cyc);
    checks++; if (idx !== 1) begin errors++; $display("FAIL drop_ack: got %0d expected 1", idx); end
    checks++; if (q_reg !== 8'hF0 || reg_din !== 8'hF0) begin errors++; $display("FAIL drop_data: got q %h din %h expected f0", q_reg, reg_din); end
    step();
  endtask
  task automatic test_reset_in_load();
    req_data = 32'h0000005A;
    req = 4'b0001;
    step();
    checks++; if (reg_load !== 1'b1) begin errors++; $display("FAIL rstload_pre: got %b expected 1", reg_load); end
    reset_n = 1'b0;
    #1;
    checks++; if (reg_load !== 1'b0 || busy !== 1'b0 || reg_din !== 8'h00) begin errors++; $display("FAIL rstload_async: got load %b busy %b din %h expected 0 0 00", reg_load, busy, reg_din); end
    req = '0;
    step();
    reset_n = 1'b1;
    lg_m = 3;
    step();
    step();
    checks++; if (ack !== 4'h0 || busy !== 1'b0 || last_grant !== 2'd3) begin errors++; $display("FAIL rstload_after: got ack %h busy %b lg %0d expected 0 0 3", ack, busy, last_grant); end
  endtask
  task automatic test_random();
    int idx, loads, cyc, exp_i;
    logic [7:0] ld;
    logic [7:0] d[4];
    logic [3:0] pm = '0;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 4; j++)
        if (!pm[j] && $urandom_range(0, 1) == 1) begin pm[j] = 1'b1; d[j] = 8'($urandom); req_data[j*8 +: 8] = d[j]; end
      if (pm == 0) begin pm[0] = 1'b1; d[0] = 8'($urandom); req_data[7:0] = d[0]; end
      req = pm;
      exp_i = pick(pm, lg_m);
      wait_ack(idx, loads, ld, cyc);
      pm[exp_i] = 1'b0;
      req = pm;
      lg_m = exp_i;
      checks++; if (idx !== exp_i) begin errors++; $display("FAIL rand_winner[%0d]: got %0d expected %0d", it, idx, exp_i); end
      checks++; if (loads !== 1 || ld !== d[exp_i]) begin errors++; $display("FAIL rand_load[%0d]: got %0d pulses din %h expected 1 pulse din %h", it, loads, ld, d[exp_i]); end
      checks++; if (q_reg !== d[exp_i]) begin errors++; $display("FAIL rand_q[%0d]: got %h expected %h", it, q_reg, d[exp_i]); end
    end
    req = '0;
    step();
    checks++; if (last_grant !== 2'(lg_m)) begin errors++; $display("FAIL rand_last_grant: got %0d expected %0d", last_grant, lg_m); end
  endtask
  task automatic test_readback();
    int idx, loads, cyc;
    logic [7:0] ld;
    force_en = 1'b1;
    force_val = 8'h00;
    req_data = 32'h000000A5;
    req = 4'b0001;
    wait_ack(idx, loads, ld, cyc);
    req = '0;
    step();
    force_en = 1'b0;
    checks++; if (rb_err !== RB) begin errors++; $display("FAIL rb_set: got %b expected %b", rb_err, RB); end
    req_data = 32'h0000003C;
    req = 4'b0001;
    wait_ack(idx, loads, ld, cyc);
    req = '0;
    step();
    checks++; if (rb_err !== RB || q_reg !== 8'h3C) begin errors++; $display("FAIL rb_sticky: got err %b q %h expected err %b q 3c", rb_err, q_reg, RB); end
    do_reset();
    checks++; if (rb_err !== 1'b0) begin errors++; $display("FAIL rb_clear: got %b expected 0", rb_err); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_all_four();
    test_single();
    test_wrap();
    test_req_drop();
    test_reset_in_load();
    test_random();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin load controller that shares the single load port of one N-bit load-enabled register (`Reg_N_bits`) among `NREQ` requesters. The arbiter accepts one write request at a time and latches the winner's data. It then drives a one-cycle `load` pulse into the register and acknowledges the winning requester. It sits directly in front of `Reg_N_bits`, whose `Din`/`load` it owns exclusively.

## Interface
- `WIDTH`, default 8: data width; must match the register's `size`.
- `NREQ`, default 4: number of requesters, range 2..16.
- `IW`, default `$clog2(NREQ)`: index width; derived, not overridden.

- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester write request; held high until `ack`.
- `req_data`  in  NREQ*WIDTH  packed data; requester i at `[i*WIDTH +: WIDTH]`.
- `ack`  out  NREQ  one-hot, one-cycle completion pulse.
- `reg_din`  out  WIDTH  registered data to the register's `Din`.
- `reg_load`  out  1  registered one-cycle load strobe to the register's `load`.
- `reg_q`  in  WIDTH  register `Q`; used only under `REG_ARB_READBACK_EN`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `last_grant`  out  IW  index of the most recently completed requester.
- `rb_err`  out  1  sticky readback mismatch flag; tied 0 without the macro.

## Operation
- FSM states are IDLE, LOAD, CHECK and ACK; CHECK exists only with the macro.
- IDLE, with `req` ≠ 0:
  - pick the first set bit scanning upward from `(last_grant+1) mod NREQ`, with wrap-around;
  - latch the winner index and its `req_data` slice into `reg_din`;
  - go to LOAD.
- IDLE, with `req` = 0: stay in IDLE; `reg_load` = 0.
- LOAD: `reg_load` = 1 for exactly this cycle; `reg_din` is stable. Next state is CHECK with the macro, otherwise ACK.
- CHECK: compare `reg_q` against latched data; a mismatch sets `rb_err`. Go to ACK.
- ACK:
  - `ack[idx]` = 1 for this cycle only;
  - `last_grant` ← idx;
  - go to IDLE.
- `reg_din` holds the last loaded value between transactions, so `reg_load` glitches never corrupt data.
- Winner's data is sampled once, at the IDLE→LOAD edge. Later changes to `req_data` are ignored.
- `req` dropped mid-transaction: the transaction still completes and `ack` still pulses. The requester must tolerate an unexpected ack.
- Requesters deassert `req` in the cycle after `ack`. A `req` still high in IDLE is re-arbitrated as a new request, but only after all other pending requesters (round-robin).
- New requests arriving while `busy` are not lost; they are considered at the next IDLE.
- Reset values (async on `reset_n` low, any state, including mid-transaction):
  - state = IDLE;
  - `ack` = 0, `reg_load` = 0, `reg_din` = 0;
  - `last_grant` = NREQ-1, so requester 0 wins first;
  - `busy` = 0, `rb_err` = 0.
- A reset during LOAD drops `reg_load` immediately. Register contents are then undefined from the arbiter's view.

## Timing
- `req` sampled high in IDLE at edge k. Then:
  - cycle k+1: LOAD, `reg_load` high;
  - edge k+2: register captures;
  - cycle k+2: ACK, or CHECK with the macro;
  - cycle k+3: IDLE, or ACK with the macro.
- Latency from request to ack is 2 cycles (3 with the macro).
- Throughput is one write per 3 cycles (4 with the macro).
- `ack`, `reg_load` and `reg_din` are all flop outputs, with no combinational path from `req`.
- `reg_q` is sampled in CHECK, one full cycle after the capture edge.

## Configuration
- `REG_ARB_READBACK_EN` defined: the CHECK state, `reg_q` compare and sticky `rb_err` are compiled in. `rb_err` is cleared only by reset.
- `REG_ARB_READBACK_EN` undefined: no CHECK state; `reg_q` is unused; `rb_err` is tied 0.

## Structure
- Package `reg_arb_pkg`: the state enum (IDLE, LOAD, CHECK, ACK) and the reset constant for `last_grant`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and a start index; outputs are `valid` and the winner index.
- The FSM, data latch and readback logic stay in `reg_load_arbiter`.

## Test plan
- Reset with all `req` high → `ack` = 0, `reg_load` = 0, `reg_din` = 0, `busy` = 0. Release reset → first `ack` goes to requester 0.
- Only `req[2]` high with data 0xFF → `reg_load` pulses one cycle with `reg_din` = 0xFF, then `ack[2]` pulses; register Q = 0xFF.
- All four requesting, with data 0x11/0x22/0x33/0x44, each dropping `req` after its ack → acks in order 0,1,2,3 and Q sequence 0x11, 0x22, 0x33, 0x44.
- `last_grant` = 2; `req[0]`, `req[1]` and `req[3]` high → order 3, 0, 1 (wrap-around).
- `req[1]` dropped during LOAD with data 0xF0 → transaction completes, Q = 0xF0, `ack[1]` pulses. Reset asserted in LOAD → `reg_load` falls immediately, state is IDLE.
- With the macro, the bench forces `reg_q` = 0x00 after a load of 0xA5 → `rb_err` goes high and stays high through later good writes until reset.
